// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: owns the fetch PC, reads instruction memory over req/ack,
// and presents the latched word with its PC and a valid flag to the decode stage.
module instr_fetch_unit #(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(32'hBFC0_0000),
  parameter int                PC_INC   = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [31:0]       mem_rdata,
  input  logic              stall,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic [31:0]       instr,
  output logic [5:0]        opcode,
  output logic [ADDR_W-1:0] pc,
  output logic              instr_valid
);

  typedef enum logic [1:0] {
    BUBBLE = 2'd0,
    FETCH  = 2'd1,
    ISSUE  = 2'd2
  } state_t;

  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] fetch_pc_reg, fetch_pc_next;
  logic [ADDR_W-1:0] pending_pc_reg, pending_pc_next;
  logic              squash_reg, squash_next;
  logic [31:0]       instr_reg, instr_next;
  logic [ADDR_W-1:0] pc_reg, pc_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= BUBBLE;
      fetch_pc_reg   <= RESET_PC;
      pending_pc_reg <= '0;
      squash_reg     <= 1'b0;
      instr_reg      <= '0;
      pc_reg         <= '0;
    end else begin
      state_reg      <= state_next;
      fetch_pc_reg   <= fetch_pc_next;
      pending_pc_reg <= pending_pc_next;
      squash_reg     <= squash_next;
      instr_reg      <= instr_next;
      pc_reg         <= pc_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    fetch_pc_next   = fetch_pc_reg;
    pending_pc_next = pending_pc_reg;
    squash_next     = squash_reg;
    instr_next      = instr_reg;
    pc_next         = pc_reg;
    unique case (state_reg)
      BUBBLE: begin
        if (redirect) fetch_pc_next = redirect_pc;
        state_next = FETCH;
      end
      FETCH: begin
        if (mem_ack) begin
          if (redirect) begin
            fetch_pc_next = redirect_pc;
            squash_next   = 1'b0;
            state_next    = BUBBLE;
          end else if (squash_reg) begin
            // Response belongs to the abandoned stream; jump to the remembered target.
            fetch_pc_next = pending_pc_reg;
            squash_next   = 1'b0;
            state_next    = BUBBLE;
          end else begin
            instr_next    = mem_rdata;
            pc_next       = fetch_pc_reg;
            fetch_pc_next = fetch_pc_reg + ADDR_W'(PC_INC);
            state_next    = ISSUE;
          end
        end else if (redirect) begin
          // Address must stay stable until ack, so defer the redirect.
          pending_pc_next = redirect_pc;
          squash_next     = 1'b1;
        end
      end
      ISSUE: begin
        if (redirect) begin
          fetch_pc_next = redirect_pc;
          state_next    = FETCH;
        end else if (!stall) begin
          state_next = FETCH;
        end
      end
      default: state_next = BUBBLE;
    endcase
  end

  assign mem_req     = (state_reg == FETCH);
  assign mem_addr    = fetch_pc_reg;
  assign instr_valid = (state_reg == ISSUE);
  assign instr       = instr_reg;
  assign pc          = pc_reg;
  assign opcode      = instr_reg[31:26];

endmodule
